// File: rtl/pipe_trace_buffer.sv
// Instruction-trace capture buffer with pre-trigger history and drain port.
// Captures PC/instr samples, triggers on PC match or external, then drains.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   trace_valid/pc/instr  sample stream from the core
//   arm                 start capture (IDLE only)
//   trig_pc_en/trig_pc  PC-match trigger
//   trig_ext            external trigger, qualified by trace_valid
//   rd_valid/ready      drain handshake; rd_pc/rd_instr/rd_last payload
//   state               0=IDLE 1=PRE 2=POST 3=DRAIN
//   count               entries stored and not yet read
module pipe_trace_buffer #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 16,
    parameter int PRE_TRIG = 4,
    parameter int CW       = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            trace_valid,
    input  logic [XLEN-1:0] trace_pc,
    input  logic [XLEN-1:0] trace_instr,
    input  logic            arm,
    input  logic            trig_pc_en,
    input  logic [XLEN-1:0] trig_pc,
    input  logic            trig_ext,
    output logic            rd_valid,
    input  logic            rd_ready,
    output logic [XLEN-1:0] rd_pc,
    output logic [XLEN-1:0] rd_instr,
    output logic            rd_last,
    output logic [1:0]      state,
    output logic [CW-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] PRE_N  = CW'(PRE_TRIG);
    localparam logic [CW-1:0] POST_N = CW'(DEPTH - PRE_TRIG);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRE   = 2'd1,
        POST  = 2'd2,
        DRAIN = 2'd3
    } st_t;

    st_t             st;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   pre_cnt;
    logic [CW-1:0]   post_cnt;
    logic [CW-1:0]   drain_cnt;
    logic [2*XLEN-1:0] mem [DEPTH];

    logic trig;
    logic we;
    logic [2*XLEN-1:0] rd_word;

    assign trig = trace_valid &&
                  ((trig_pc_en && (trace_pc == trig_pc)) || trig_ext);

    assign we = !reset && trace_valid && ((st == PRE) || (st == POST));

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_ptr] <= {trace_pc, trace_instr};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st        <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            pre_cnt   <= '0;
            post_cnt  <= '0;
            drain_cnt <= '0;
        end else begin
            unique case (st)
                IDLE: begin
                    if (arm) begin
                        st       <= PRE;
                        wr_ptr   <= '0;
                        pre_cnt  <= '0;
                        post_cnt <= '0;
                    end
                end
                PRE: begin
                    if (trace_valid) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        if (trig) begin
                            // Oldest retained pre sample becomes the read start.
                            rd_ptr   <= wr_ptr - PW'(pre_cnt);
                            post_cnt <= CW'(1);
                            if (POST_N == CW'(1)) begin
                                st        <= DRAIN;
                                drain_cnt <= pre_cnt + CW'(1);
                            end else begin
                                st <= POST;
                            end
                        end else if (pre_cnt != PRE_N) begin
                            pre_cnt <= pre_cnt + CW'(1);
                        end
                    end
                end
                POST: begin
                    if (trace_valid) begin
                        wr_ptr   <= wr_ptr + 1'b1;
                        post_cnt <= post_cnt + CW'(1);
                        if (post_cnt + CW'(1) == POST_N) begin
                            st        <= DRAIN;
                            drain_cnt <= pre_cnt + POST_N;
                        end
                    end
                end
                DRAIN: begin
                    if (rd_ready) begin
                        rd_ptr    <= rd_ptr + 1'b1;
                        drain_cnt <= drain_cnt - CW'(1);
                        if (drain_cnt == CW'(1)) begin
                            st       <= IDLE;
                            pre_cnt  <= '0;
                            post_cnt <= '0;
                        end
                    end
                end
            endcase
        end
    end

    assign rd_word  = mem[rd_ptr];
    assign rd_valid = (st == DRAIN);
    assign rd_last  = (st == DRAIN) && (drain_cnt == CW'(1));
    assign rd_pc    = rd_valid ? rd_word[2*XLEN-1:XLEN] : '0;
    assign rd_instr = rd_valid ? rd_word[XLEN-1:0] : '0;
    assign state    = st;
    assign count    = (st == DRAIN) ? drain_cnt : (pre_cnt + post_cnt);

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Directed self-checking bench for pipe_trace_buffer.
// DEPTH=8, PRE_TRIG=3: five post samples, up to eight entries per capture.
module tb_pipe_trace_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        trace_valid;
    logic [31:0] trace_pc;
    logic [31:0] trace_instr;
    logic        arm;
    logic        trig_pc_en;
    logic [31:0] trig_pc;
    logic        trig_ext;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_pc;
    logic [31:0] rd_instr;
    logic        rd_last;
    logic [1:0]  state;
    logic [3:0]  count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_trace_buffer #(
        .XLEN(32), .DEPTH(8), .PRE_TRIG(3)
    ) dut (
        .clk(clk), .reset(reset),
        .trace_valid(trace_valid), .trace_pc(trace_pc),
        .trace_instr(trace_instr), .arm(arm),
        .trig_pc_en(trig_pc_en), .trig_pc(trig_pc),
        .trig_ext(trig_ext), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .rd_pc(rd_pc),
        .rd_instr(rd_instr), .rd_last(rd_last),
        .state(state), .count(count)
    );

    function automatic logic [31:0] ins(input logic [31:0] pc);
        return {16'hC0DE, pc[15:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] pc, input logic v, input logic e);
        trace_valid = v;
        trace_pc    = pc;
        trace_instr = ins(pc);
        trig_ext    = e;
        tick();
        trace_valid = 1'b0;
        trig_ext    = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        total++;
        if ({state, count, rd_valid, rd_last} !== 8'h00) begin
            bad++;
            $display("FAIL reset_ctl st=%0d cnt=%0d v=%b l=%b need 0", state, count, rd_valid, rd_last);
        end
        total++;
        if ({rd_pc, rd_instr} !== 64'h0) begin
            bad++;
            $display("FAIL reset_data pc=%h ins=%h need 0", rd_pc, rd_instr);
        end
    endtask

    task automatic test_pc_trigger();
        trig_pc_en = 1'b1;
        trig_pc    = 32'h18;
        do_arm();
        total++;
        if (state !== 2'd1) begin
            bad++;
            $display("FAIL t1_arm st=%0d need 1", state);
        end
        for (int i = 0; i < 6; i++) send(32'(4 * i), 1'b1, 1'b0);
        total++;
        if ({state, count} !== {2'd1, 4'd3}) begin
            bad++;
            $display("FAIL t1_pre st=%0d cnt=%0d need 1/3", state, count);
        end
        send(32'h18, 1'b1, 1'b0);
        total++;
        if ({state, count} !== {2'd2, 4'd4}) begin
            bad++;
            $display("FAIL t1_trig st=%0d cnt=%0d need 2/4", state, count);
        end
        for (int i = 0; i < 4; i++) send(32'h1C + 32'(4 * i), 1'b1, 1'b0);
        total++;
        if ({state, count, rd_valid} !== {2'd3, 4'd8, 1'b1}) begin
            bad++;
            $display("FAIL t1_drain st=%0d cnt=%0d v=%b need 3/8/1", state, count, rd_valid);
        end
        send(32'h2C, 1'b1, 1'b0);
        total++;
        if ({rd_pc, count} !== {32'h0C, 4'd8}) begin
            bad++;
            $display("FAIL t1_ignore pc=%h cnt=%0d need 0c/8", rd_pc, count);
        end
        rd_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            total++;
            if ({rd_valid, rd_pc, rd_instr, rd_last} !==
                {1'b1, 32'h0C + 32'(4 * k), ins(32'h0C + 32'(4 * k)), k == 7}) begin
                bad++;
                $display("FAIL t1_rd%0d v=%b pc=%h ins=%h l=%b", k, rd_valid, rd_pc, rd_instr, rd_last);
            end
            tick();
        end
        rd_ready = 1'b0;
        total++;
        if ({state, count, rd_valid} !== 7'h00) begin
            bad++;
            $display("FAIL t1_end st=%0d cnt=%0d v=%b need 0", state, count, rd_valid);
        end
    endtask

    task automatic test_first_trigger();
        trig_pc_en = 1'b0;
        do_arm();
        send(32'h00, 1'b1, 1'b1);
        total++;
        if ({state, count} !== {2'd2, 4'd1}) begin
            bad++;
            $display("FAIL t2_trig st=%0d cnt=%0d need 2/1", state, count);
        end
        for (int i = 1; i < 5; i++) send(32'(4 * i), 1'b1, 1'b0);
        total++;
        if ({state, count} !== {2'd3, 4'd5}) begin
            bad++;
            $display("FAIL t2_drain st=%0d cnt=%0d need 3/5", state, count);
        end
        rd_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            total++;
            if ({rd_valid, rd_pc, rd_instr, rd_last} !==
                {1'b1, 32'(4 * k), ins(32'(4 * k)), k == 4}) begin
                bad++;
                $display("FAIL t2_rd%0d v=%b pc=%h ins=%h l=%b", k, rd_valid, rd_pc, rd_instr, rd_last);
            end
            tick();
        end
        rd_ready = 1'b0;
        total++;
        if ({state, rd_valid} !== 3'b000) begin
            bad++;
            $display("FAIL t2_end st=%0d v=%b need 0", state, rd_valid);
        end
    endtask

    task automatic test_gaps();
        logic [31:0] exp_pc [7];
        exp_pc = '{32'h30, 32'h38, 32'h40, 32'h44, 32'h48, 32'h4C, 32'h50};
        trig_pc_en = 1'b0;
        do_arm();
        send(32'h30, 1'b1, 1'b0);
        send(32'h34, 1'b0, 1'b1);
        send(32'h38, 1'b1, 1'b0);
        send(32'h3C, 1'b0, 1'b1);
        total++;
        if ({state, count} !== {2'd1, 4'd2}) begin
            bad++;
            $display("FAIL t3_gap st=%0d cnt=%0d need 1/2", state, count);
        end
        send(32'h40, 1'b1, 1'b1);
        total++;
        if ({state, count} !== {2'd2, 4'd3}) begin
            bad++;
            $display("FAIL t3_trig st=%0d cnt=%0d need 2/3", state, count);
        end
        send(32'h44, 1'b1, 1'b0);
        send(32'h99, 1'b0, 1'b0);
        total++;
        if (count !== 4'd4) begin
            bad++;
            $display("FAIL t3_postgap cnt=%0d need 4", count);
        end
        for (int i = 0; i < 3; i++) send(32'h48 + 32'(4 * i), 1'b1, 1'b0);
        total++;
        if ({state, count} !== {2'd3, 4'd7}) begin
            bad++;
            $display("FAIL t3_drain st=%0d cnt=%0d need 3/7", state, count);
        end
        rd_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            total++;
            if ({rd_pc, rd_instr, rd_last} !== {exp_pc[k], ins(exp_pc[k]), k == 6}) begin
                bad++;
                $display("FAIL t3_rd%0d pc=%h ins=%h l=%b need %h", k, rd_pc, rd_instr, rd_last, exp_pc[k]);
            end
            tick();
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        trig_pc_en = 1'b1;
        trig_pc    = 32'h118;
        do_arm();
        for (int i = 0; i < 11; i++) send(32'h100 + 32'(4 * i), 1'b1, 1'b0);
        rd_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (rd_pc !== 32'h10C + 32'(4 * k)) begin
                bad++;
                $display("FAIL t4_pre%0d pc=%h need %h", k, rd_pc, 32'h10C + 32'(4 * k));
            end
            tick();
        end
        rd_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            total++;
            if ({rd_valid, rd_pc, rd_instr, rd_last, count} !==
                {1'b1, 32'h118, ins(32'h118), 1'b0, 4'd5}) begin
                bad++;
                $display("FAIL t4_hold%0d v=%b pc=%h l=%b cnt=%0d", c, rd_valid, rd_pc, rd_last, count);
            end
            tick();
        end
        rd_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            total++;
            if ({rd_pc, rd_instr, rd_last} !==
                {32'h118 + 32'(4 * k), ins(32'h118 + 32'(4 * k)), k == 4}) begin
                bad++;
                $display("FAIL t4_rd%0d pc=%h ins=%h l=%b", k, rd_pc, rd_instr, rd_last);
            end
            tick();
        end
        rd_ready = 1'b0;
        total++;
        if (state !== 2'd0) begin
            bad++;
            $display("FAIL t4_end st=%0d need 0", state);
        end
    endtask

    task automatic test_reset_mid();
        trig_pc_en = 1'b0;
        do_arm();
        send(32'h500, 1'b1, 1'b0);
        send(32'h504, 1'b1, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if ({state, count, rd_valid} !== 7'h00) begin
            bad++;
            $display("FAIL t5_post st=%0d cnt=%0d v=%b need 0", state, count, rd_valid);
        end
        reset = 1'b1;
        arm   = 1'b1;
        tick();
        reset = 1'b0;
        arm   = 1'b0;
        total++;
        if (state !== 2'd0) begin
            bad++;
            $display("FAIL t5_armrst st=%0d need 0", state);
        end
        do_arm();
        send(32'h600, 1'b1, 1'b1);
        for (int i = 1; i < 5; i++) send(32'h600 + 32'(4 * i), 1'b1, 1'b0);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if ({state, count, rd_valid, rd_last} !== 8'h00) begin
            bad++;
            $display("FAIL t5_drain st=%0d cnt=%0d v=%b need 0", state, count, rd_valid);
        end
        do_arm();
        send(32'h200, 1'b1, 1'b1);
        for (int i = 1; i < 5; i++) send(32'h200 + 32'(4 * i), 1'b1, 1'b0);
        total++;
        if ({state, count} !== {2'd3, 4'd5}) begin
            bad++;
            $display("FAIL t5_fresh st=%0d cnt=%0d need 3/5", state, count);
        end
        rd_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            total++;
            if ({rd_pc, rd_last} !== {32'h200 + 32'(4 * k), k == 4}) begin
                bad++;
                $display("FAIL t5_rd%0d pc=%h l=%b", k, rd_pc, rd_last);
            end
            tick();
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_arm_ignored();
        trig_pc_en = 1'b1;
        trig_pc    = 32'h900;
        do_arm();
        send(32'h300, 1'b1, 1'b0);
        send(32'h304, 1'b1, 1'b0);
        arm = 1'b1;
        send(32'h308, 1'b1, 1'b0);
        arm = 1'b0;
        total++;
        if ({state, count} !== {2'd1, 4'd3}) begin
            bad++;
            $display("FAIL t6_armpre st=%0d cnt=%0d need 1/3", state, count);
        end
        trig_pc_en = 1'b0;
        trig_pc    = 32'h30C;
        send(32'h30C, 1'b1, 1'b0);
        total++;
        if ({state, count} !== {2'd1, 4'd3}) begin
            bad++;
            $display("FAIL t6_pcdis st=%0d cnt=%0d need 1/3", state, count);
        end
        trig_pc_en = 1'b1;
        trig_pc    = 32'h310;
        send(32'h310, 1'b1, 1'b0);
        arm = 1'b1;
        send(32'h314, 1'b1, 1'b0);
        arm = 1'b0;
        total++;
        if ({state, count} !== {2'd2, 4'd5}) begin
            bad++;
            $display("FAIL t6_armpost st=%0d cnt=%0d need 2/5", state, count);
        end
        for (int i = 0; i < 3; i++) send(32'h318 + 32'(4 * i), 1'b1, 1'b0);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        total++;
        if ({state, count, rd_pc} !== {2'd3, 4'd8, 32'h304}) begin
            bad++;
            $display("FAIL t6_armdrain st=%0d cnt=%0d pc=%h need 3/8/304", state, count, rd_pc);
        end
        rd_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            total++;
            if ({rd_pc, rd_instr, rd_last} !==
                {32'h304 + 32'(4 * k), ins(32'h304 + 32'(4 * k)), k == 7}) begin
                bad++;
                $display("FAIL t6_rd%0d pc=%h ins=%h l=%b", k, rd_pc, rd_instr, rd_last);
            end
            tick();
        end
        rd_ready = 1'b0;
        total++;
        if ({state, rd_valid} !== 3'b000) begin
            bad++;
            $display("FAIL t6_end st=%0d v=%b need 0", state, rd_valid);
        end
    endtask

    initial begin
        reset       = 1'b1;
        trace_valid = 1'b0;
        trace_pc    = '0;
        trace_instr = '0;
        arm         = 1'b0;
        trig_pc_en  = 1'b0;
        trig_pc     = '0;
        trig_ext    = 1'b0;
        rd_ready    = 1'b0;
        test_reset();
        test_pc_trigger();
        test_first_trigger();
        test_gaps();
        test_backpressure();
        test_reset_mid();
        test_arm_ignored();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_trace_buffer.md
Name: pipe_trace_buffer

Overview:
- Parametrised instruction-trace capture buffer that sits beside the RicsV_Pipelined core on the PC_cur / Instruction_cur pair.
- It replaces print-per-clock monitoring with an on-chip logic-analyser function: armed capture, pre-trigger history, PC-match or external trigger, post-trigger fill, then valid/ready drain.
- It is usable in simulation and in silicon debug.

Parameters:
- XLEN, 32: width of the PC and instruction fields.
- DEPTH, 16: number of stored entries. Must be a power of two, ≥4.
- PRE_TRIG, 4: maximum number of samples kept from before the trigger. Range 0..DEPTH-1.
- CW, $clog2(DEPTH+1): width of the count output (derived).

Ports:
- clk  in  1  clock; everything is rising-edge.
- reset  in  1  synchronous, active-high reset.
- trace_valid  in  1  the trace_pc/trace_instr sample is valid this cycle.
- trace_pc  in  XLEN  PC of the sample (core PC_cur).
- trace_instr  in  XLEN  instruction of the sample (core Instruction_cur).
- arm  in  1  one-cycle pulse that starts capture. Only accepted in IDLE.
- trig_pc_en  in  1  enables the PC-match trigger.
- trig_pc  in  XLEN  PC value to match.
- trig_ext  in  1  external trigger, qualified by trace_valid.
- rd_valid  out  1  a readout entry is available.
- rd_ready  in  1  the consumer accepts the entry.
- rd_pc  out  XLEN  PC of the current readout entry.
- rd_instr  out  XLEN  instruction of the current readout entry.
- rd_last  out  1  the current readout entry is the final one.
- state  out  2  0=IDLE, 1=PRE, 2=POST, 3=DRAIN.
- count  out  CW  number of entries currently stored and not yet read.

Behaviour:
- Reset values: state=IDLE, count=0, rd_valid=0, rd_last=0, rd_pc=0, rd_instr=0. Pointers and counters are cleared. The storage array is not reset.
- Reset asserted in any state, including mid-drain, wins: IDLE on the next edge and any partial capture is discarded.
- Trigger condition:
  - trig = trace_valid && ((trig_pc_en && trace_pc==trig_pc) || trig_ext).
  - trig_ext without trace_valid is ignored.
- IDLE:
  - No writes.
  - arm=1 → PRE. wr_ptr=0, pre_cnt=0.
- PRE:
  - Each trace_valid && !trig writes {pc,instr} at wr_ptr, then wr_ptr=(wr_ptr+1) mod DEPTH.
  - pre_cnt increments and saturates at PRE_TRIG.
  - Circular wrap: the oldest entry is overwritten, and the last PRE_TRIG samples are the ones retained.
  - On trig, that sample is written and recorded as the first post entry:
    - start_ptr = wr_ptr - pre_cnt (mod DEPTH).
    - post_cnt = 1.
    - Go to POST, or go directly to DRAIN if DEPTH-PRE_TRIG==1.
  - A trigger on the very first valid sample gives pre_cnt=0.
- POST:
  - Each trace_valid writes the sample and increments post_cnt.
  - Trigger inputs are ignored in POST.
  - When post_cnt reaches DEPTH-PRE_TRIG on a write, go to DRAIN on the same edge.
  - Total stored = pre_cnt + (DEPTH-PRE_TRIG) ≤ DEPTH, so post samples never overwrite the retained pre samples.
- DRAIN:
  - rd_ptr starts at start_ptr. count = stored total.
  - rd_valid=1 from the first cycle in DRAIN.
  - rd_pc/rd_instr = entry[rd_ptr], with zero added latency from rd_ptr.
  - On rd_valid && rd_ready: rd_ptr advances mod DEPTH and count decrements.
  - While rd_ready=0, rd_pc, rd_instr and rd_last hold stable.
  - rd_last=1 when count==1.
  - On the handshake with rd_last=1 → IDLE, and rd_valid=0 on the next cycle.
  - trace_valid is ignored in DRAIN: no writes, and the loss is not counted.
- In PRE/POST, count = pre_cnt + post_cnt (live fill level).
- arm outside IDLE is ignored.
- arm in the same cycle as reset: reset wins.
- Widths: all pointer arithmetic is mod DEPTH. count never exceeds DEPTH.
- PC compare is full XLEN equality.

Test Plan:
1. DEPTH=8, PRE_TRIG=3. Arm, then stream PC 0x00,0x04,… with trace_valid=1 and trig_pc=0x18, trig_pc_en=1.
   - Expected: PRE keeps 0x0C,0x10,0x14. POST captures 0x18..0x28.
   - DRAIN with rd_ready=1 yields 8 entries 0x0C..0x28 with matching instr. rd_last only on 0x28. Then IDLE.
2. Same config, trigger on the first sample (trig_ext=1 with PC 0x00).
   - Expected: 5 entries 0x00..0x10, count=5 on entering DRAIN, rd_last on 0x10.
3. Gaps and a qualified external trigger.
   - trace_valid toggled 1,0,1,0 with trig_ext pulsed on a trace_valid=0 cycle.
   - Expected: no trigger and no write on invalid cycles. A later trig_ext with valid PC 0x40 triggers. Only valid samples are stored.
4. Backpressure during drain: rd_ready held 0 for 5 cycles mid-drain.
   - Expected: rd_valid=1, rd_pc/rd_instr/rd_last unchanged, count unchanged. The drain then resumes in order with no loss.
5. Reset mid-operation: reset=1 for one cycle during POST and again during DRAIN.
   - Expected: next cycle state=0, count=0, rd_valid=0. A fresh arm captures correctly.
6. arm pulsed during PRE/POST/DRAIN.
   - Expected: ignored, with no pointer reset.
   - Also check PC-match with trig_pc_en=0: a matching PC does not trigger.
